// File: rtl/dsp_bus_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_bus_sequencer
//   Front end between the asynchronous DSP bus pins and the bus app modules.
//   It synchronises the DSP strobes, latches the address and write data, issues
//   one-cycle write/read qualifier pulses to the apps, and arbitrates the apps'
//   read data onto the pad output path together with the output enable.
//
// Ports
//   xclk, reset            system clock; async active-high reset
//   dsp_cs_n/rd_n/wr_n     raw DSP strobes (async, active-low)
//   ab_pins, db_pins_in    raw DSP address / data-in pins
//   ab, db_in              latched address / write data to the apps
//   write_qualified        1-cycle write pulse to the apps
//   read_qualified         1-cycle read pulse to the apps
//   app_db_out, app_avail  per-app read data (16 bits each) and valid flags
//   db_out, db_oe          read data and output enable for the pad buffer
//   bus_error              sticky protocol/arbitration error flag
//   txn_count              completed transactions, wrapping
// -----------------------------------------------------------------------------
module dsp_bus_sequencer #(
  parameter int NUM_APPS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic                     xclk,
  input  logic                     reset,
  input  logic                     dsp_cs_n,
  input  logic                     dsp_rd_n,
  input  logic                     dsp_wr_n,
  input  logic [7:0]               ab_pins,
  input  logic [15:0]              db_pins_in,
  output logic [7:0]               ab,
  output logic [15:0]              db_in,
  output logic                     write_qualified,
  output logic                     read_qualified,
  input  logic [16*NUM_APPS-1:0]   app_db_out,
  input  logic [NUM_APPS-1:0]      app_avail,
  output logic [15:0]              db_out,
  output logic                     db_oe,
  output logic                     bus_error,
  output logic [15:0]              txn_count
);

  typedef enum logic [2:0] {
    IDLE,
    WR_QUAL,
    RD_QUAL,
    RD_WAIT,
    RD_DRIVE,
    WAIT_REL
  } state_t;

  // The counter runs 0..RD_TIMEOUT-1 while in RD_DRIVE, so the drive phase
  // lasts exactly RD_TIMEOUT cycles before it is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(RD_TIMEOUT - 1);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
  logic cs_s, rd_s, wr_s;
  logic rd_prev, wr_prev;
  logic rd_fall, wr_fall;

  logic [7:0]  to_cnt;
  logic        timeout_hit;

  logic [15:0] sel_data;
  logic        multi_avail;
  logic        found;

  logic latch_addr, latch_data, load_rd, oe_clr, set_err, txn_inc;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers. Idle level of every strobe is high, so the chains
  // come out of reset high and no false falling edge is seen afterwards.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the synchroniser chain.
  // ---------------------------------------------------------------------------
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      cs_sync <= '1;
      rd_sync <= '1;
      wr_sync <= '1;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], dsp_cs_n};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], dsp_rd_n};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], dsp_wr_n};
      rd_prev <= rd_s;
      wr_prev <= wr_s;
    end
  end

  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];

  assign rd_fall = !rd_s && rd_prev && !cs_s;
  assign wr_fall = !wr_s && wr_prev && !cs_s;

  // ---------------------------------------------------------------------------
  // Read-data arbitration: lowest-index available app wins; more than one
  // available app is flagged as an error. No app available reads as all-ones.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_data    = 16'hFFFF;
    multi_avail = 1'b0;
    found       = 1'b0;
    for (int i = 0; i < NUM_APPS; i++) begin
      if (app_avail[i]) begin
        if (found) begin
          multi_avail = 1'b1;
        end else begin
          sel_data = app_db_out[16*i +: 16];
          found    = 1'b1;
        end
      end
    end
  end

  assign timeout_hit = (to_cnt == TIMEOUT_LAST);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    load_rd    = 1'b0;
    oe_clr     = 1'b0;
    set_err    = 1'b0;
    txn_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_fall && rd_fall) begin
          set_err = 1'b1;
        end else if (wr_fall) begin
          latch_addr = 1'b1;
          latch_data = 1'b1;
          state_next = WR_QUAL;
        end else if (rd_fall) begin
          latch_addr = 1'b1;
          state_next = RD_QUAL;
        end
      end
      WR_QUAL: begin
        txn_inc    = 1'b1;
        state_next = WAIT_REL;
      end
      RD_QUAL:  state_next = RD_WAIT;
      RD_WAIT: begin
        // Apps present registered data one cycle after read_qualified.
        load_rd    = 1'b1;
        set_err    = multi_avail;
        state_next = RD_DRIVE;
      end
      RD_DRIVE: begin
        if (rd_s) begin
          oe_clr     = 1'b1;
          txn_inc    = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          oe_clr     = 1'b1;
          set_err    = 1'b1;
          state_next = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (rd_s && wr_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pulses decode straight from state so a reset drops any pulse in flight.
  assign write_qualified = (state == WR_QUAL);
  assign read_qualified  = (state == RD_QUAL);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      ab        <= '0;
      db_in     <= '0;
      db_out    <= 16'hFFFF;
      db_oe     <= 1'b0;
      bus_error <= 1'b0;
      txn_count <= '0;
      to_cnt    <= '0;
    end else begin
      if (latch_addr) ab    <= ab_pins;
      if (latch_data) db_in <= db_pins_in;
      if (load_rd) begin
        db_out <= sel_data;
        db_oe  <= 1'b1;
      end else if (oe_clr) begin
        db_oe  <= 1'b0;
      end
      if (set_err) bus_error <= 1'b1;
      if (txn_inc) txn_count <= txn_count + 16'd1;
      if (state == RD_DRIVE) to_cnt <= to_cnt + 8'd1;
      else                   to_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dsp_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_bus_sequencer
//   Directed bench for dsp_bus_sequencer. Stimulus tasks push the expected
//   transaction into a queue; a monitor pops and compares whenever the DUT
//   issues a qualifier pulse or raises db_oe. Latency, timeout, count and
//   error-flag checks are made by the stimulus tasks against a small model.
// -----------------------------------------------------------------------------
module tb_dsp_bus_sequencer;

  localparam int NUM_APPS = 4;

  logic                   xclk = 1'b0;
  logic                   reset;
  logic                   dsp_cs_n, dsp_rd_n, dsp_wr_n;
  logic [7:0]             ab_pins;
  logic [15:0]            db_pins_in;
  logic [7:0]             ab;
  logic [15:0]            db_in;
  logic                   write_qualified, read_qualified;
  logic [16*NUM_APPS-1:0] app_db_out;
  logic [NUM_APPS-1:0]    app_avail;
  logic [15:0]            db_out;
  logic                   db_oe;
  logic                   bus_error;
  logic [15:0]            txn_count;

  dsp_bus_sequencer #(.NUM_APPS(NUM_APPS), .SYNC_STAGES(2), .RD_TIMEOUT(255)) dut (
    .xclk            (xclk),
    .reset           (reset),
    .dsp_cs_n        (dsp_cs_n),
    .dsp_rd_n        (dsp_rd_n),
    .dsp_wr_n        (dsp_wr_n),
    .ab_pins         (ab_pins),
    .db_pins_in      (db_pins_in),
    .ab              (ab),
    .db_in           (db_in),
    .write_qualified (write_qualified),
    .read_qualified  (read_qualified),
    .app_db_out      (app_db_out),
    .app_avail       (app_avail),
    .db_out          (db_out),
    .db_oe           (db_oe),
    .bus_error       (bus_error),
    .txn_count       (txn_count)
  );

  always #5 xclk = ~xclk;

  typedef struct {
    bit          is_rd;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          pulses_seen = 0;
  bit          rd_pend = 1'b0;
  logic [15:0] rd_pend_data;
  logic        oe_prev = 1'b0;
  logic [15:0] txn_model = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each qualifier pulse and each db_oe rise against the queue.
  always @(negedge xclk) begin
    exp_t e;
    if (write_qualified || read_qualified) begin
      pulses_seen++;
      check("pulse_has_expected_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_kind_is_read", 32'(read_qualified), 32'(e.is_rd));
        check("ab", 32'(ab), 32'(e.addr));
        if (!e.is_rd) check("db_in", 32'(db_in), 32'(e.data));
        else begin
          rd_pend      = 1'b1;
          rd_pend_data = e.data;
        end
      end
    end
    if (db_oe && !oe_prev) begin
      check("oe_rise_has_pending_read", 32'(rd_pend), 32'd1);
      check("db_out", 32'(db_out), 32'(rd_pend_data));
      rd_pend = 1'b0;
    end
    oe_prev = db_oe;
  end

  // Write transaction; strobes are driven on a falling clock edge, so the
  // pulse is expected at the 3rd negedge (2 sync flops + 1 FSM cycle).
  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit cs_ok);
    int lat, width;
    if (cs_ok) exp_q.push_back('{1'b0, a, d});
    @(negedge xclk);
    ab_pins = a; db_pins_in = d;
    dsp_cs_n = !cs_ok; dsp_wr_n = 1'b0;
    lat = 0; width = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge xclk);
      if (write_qualified) begin
        if (lat == 0) lat = i;
        width++;
      end
    end
    dsp_wr_n = 1'b1; dsp_cs_n = 1'b1;
    repeat (6) @(negedge xclk);
    if (cs_ok) begin
      txn_model = txn_model + 16'd1;
      check("wq_latency", 32'(lat), 32'd3);
      check("wq_width", 32'(width), 32'd1);
    end else begin
      check("wq_none_cs_high", 32'(width), 32'd0);
    end
    check("txn_count_after_write", 32'(txn_count), 32'(txn_model));
  endtask

  // Read transaction with rd_n held low for 'hold' cycles.
  task automatic do_read(input logic [7:0] a, input logic [NUM_APPS-1:0] av,
                         input logic [16*NUM_APPS-1:0] data, input logic [15:0] exp_d,
                         input int hold, input bit exp_timeout);
    int rq_lat, oe_lat, oe_cnt, drop_lat, pulses_before;
    exp_q.push_back('{1'b1, a, exp_d});
    app_avail = av; app_db_out = data;
    @(negedge xclk);
    ab_pins = a; dsp_cs_n = 1'b0; dsp_rd_n = 1'b0;
    rq_lat = 0; oe_lat = 0; oe_cnt = 0; drop_lat = 0; pulses_before = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge xclk);
      if (read_qualified && rq_lat == 0) rq_lat = i;
      if (db_oe) begin
        if (oe_lat == 0) oe_lat = i;
        oe_cnt++;
      end
      // After the timeout, try a write while rd_n is still low: must be ignored.
      if (exp_timeout && i == 280) begin
        pulses_before = pulses_seen;
        dsp_wr_n = 1'b0;
      end
    end
    dsp_rd_n = 1'b1; dsp_wr_n = 1'b1; dsp_cs_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge xclk);
      if (db_oe) oe_cnt++;
      else if (drop_lat == 0) drop_lat = j;
    end
    check("rq_latency", 32'(rq_lat), 32'd3);
    check("oe_latency", 32'(oe_lat), 32'd5);
    if (exp_timeout) begin
      check("oe_cycles_timeout", 32'(oe_cnt), 32'd255);
      check("no_pulse_until_release", 32'(pulses_seen), 32'(pulses_before));
    end else begin
      txn_model = txn_model + 16'd1;
      check("oe_drop_latency", 32'(drop_lat), 32'd3);
    end
    check("txn_count_after_read", 32'(txn_count), 32'(txn_model));
  endtask

  initial begin
    int waited;
    reset = 1'b1;
    dsp_cs_n = 1'b1; dsp_rd_n = 1'b1; dsp_wr_n = 1'b1;
    ab_pins = '0; db_pins_in = '0; app_db_out = '0; app_avail = '0;
    repeat (3) @(negedge xclk);
    reset = 1'b0;
    @(negedge xclk);

    // Reset state
    check("rst_ab", 32'(ab), 32'h0);
    check("rst_db_in", 32'(db_in), 32'h0);
    check("rst_wq", 32'(write_qualified), 32'h0);
    check("rst_rq", 32'(read_qualified), 32'h0);
    check("rst_db_out", 32'(db_out), 32'hFFFF);
    check("rst_db_oe", 32'(db_oe), 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    check("rst_txn_count", 32'(txn_count), 32'h0);

    // Strobes with cs_n high: nothing happens
    do_write(8'h22, 16'h5A5A, 1'b0);

    // Basic write
    do_write(8'h10, 16'h1234, 1'b1);
    check("write_ab_held", 32'(ab), 32'h10);
    check("write_db_in_held", 32'(db_in), 32'h1234);

    // Read, app1 available
    do_read(8'h31, 4'b0010, {16'h0, 16'h0, 16'hA5A5, 16'h0}, 16'hA5A5, 10, 1'b0);
    check("read1_bus_error", 32'(bus_error), 32'h0);

    // Read, nothing available
    do_read(8'h32, 4'b0000, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 16'hFFFF, 8, 1'b0);
    check("read_none_bus_error", 32'(bus_error), 32'h0);

    // txn_count wrap: preload the counter, then complete one write
    @(negedge xclk);
    force dut.txn_count = 16'hFFFF;
    @(negedge xclk);
    release dut.txn_count;
    txn_model = 16'hFFFF;
    do_write(8'h44, 16'hCAFE, 1'b1);
    check("txn_wrapped", 32'(txn_count), 32'h0);

    // Read, app0 and app2 both available -> lowest index wins, error flagged
    do_read(8'h50, 4'b0101, {16'h0, 16'h0002, 16'h0, 16'h0001}, 16'h0001, 8, 1'b0);
    check("multi_avail_bus_error", 32'(bus_error), 32'h1);

    // rd_n held low 300 cycles -> timeout
    do_read(8'h60, 4'b1000, {16'hBEEF, 16'h0, 16'h0, 16'h0}, 16'hBEEF, 300, 1'b1);
    check("timeout_bus_error", 32'(bus_error), 32'h1);

    // Reset while in RD_DRIVE
    exp_q.push_back('{1'b1, 8'h70, 16'h5555});
    app_avail = 4'b0010; app_db_out = {16'h0, 16'h0, 16'h5555, 16'h0};
    @(negedge xclk);
    ab_pins = 8'h70; dsp_cs_n = 1'b0; dsp_rd_n = 1'b0;
    waited = 0;
    while (!db_oe && waited < 20) begin
      @(negedge xclk);
      waited++;
    end
    check("pre_reset_oe_reached", 32'(waited < 20), 32'd1);
    repeat (2) @(negedge xclk);
    #2;
    reset = 1'b1;
    dsp_rd_n = 1'b1; dsp_cs_n = 1'b1;
    #1;
    check("async_reset_db_oe", 32'(db_oe), 32'h0);
    check("async_reset_bus_error", 32'(bus_error), 32'h0);
    check("async_reset_txn", 32'(txn_count), 32'h0);
    txn_model = 16'd0;
    @(negedge xclk);
    reset = 1'b0;
    repeat (3) @(negedge xclk);

    // Next read completes normally
    do_read(8'h71, 4'b0100, {16'h0, 16'h7777, 16'h0, 16'h0}, 16'h7777, 9, 1'b0);
    check("post_reset_bus_error", 32'(bus_error), 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
